stc_abuf_ctrl: RTL and testbench
================================

# stc_abuf_ctrl

Sequencer for the sparse tensor core's A-operand row buffer. It loads M rows of compressed A values and column indices from the memory stream into the buffer. It then walks the stored non-zeros row by row and issues up to four {row, col} read pointers per cycle to the buffer read port and the downstream MAC lanes, under a valid/ready handshake. It sits between the memory fetch unit and the A-buffer/PE array.

## Interface
- M, 16, rows held in the A buffer
- K, 16, max non-zeros per row (buffer slots per row)
- DW_MEM, 512, memory beat width
- DW_COL, 4, row/column index width (log2 of M and K)
- DW_PTR, 8, packed pointer width: row at [DW_COL +: DW_COL], col at [0 +: DW_COL]
- DW_CNT, DW_COL+1, per-row non-zero count width
---
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; launches one tile
- nnz_vec  in  M*DW_CNT  per-row non-zero counts; row r at [r*DW_CNT +: DW_CNT]; sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse when the last pointer group is accepted
- mem_valid  in  1  memory beat valid
- mem_ready  out  1  controller accepts beat
- mem_data  in  DW_MEM  beat payload, forwarded unchanged
- buf_write_data_en  out  1  buffer value-row write strobe
- buf_write_cidx_en  out  1  buffer column-index-row write strobe
- buf_idx  out  DW_COL  buffer row being written
- buf_data_input  out  DW_MEM  equals mem_data
- ptrs  out  4*DW_PTR  lane pointers; lane g at [g*DW_PTR +: DW_PTR]
- lane_mask  out  4  lane g carries a valid non-zero
- out_valid  out  1  ptrs/lane_mask valid
- out_ready  in  1  consumer accepts group

## Operation
- States: IDLE, LOAD_DATA, LOAD_CIDX, ISSUE, DONE.
- IDLE: busy=0 and mem_ready=0. On start, latch nnz_vec. Each count is clamped to K. Clear row counter r and offset o, then go to LOAD_DATA. start while busy is ignored.
- LOAD_DATA: mem_ready=1. On beat (mem_valid&&mem_ready), pulse buf_write_data_en with buf_idx=r, then go to LOAD_CIDX.
- LOAD_CIDX: mem_ready=1. On beat, pulse buf_write_cidx_en with buf_idx=r.
  - If r==M-1: reset r to 0 and go to ISSUE.
  - Otherwise: increment r and go to LOAD_DATA.
- Beat ordering per row is fixed: value row first, then column-index row. No beat is taken outside LOAD_* states.
- ISSUE: let n = nnz[r] - o and L = min(4, n).
  - Lanes g<L get ptr = {r, o+g}; lane_mask[g]=1. Unused lanes are 0 with mask 0.
  - A group never spans rows.
  - On accept (out_valid&&out_ready): o += L. If o reaches nnz[r], set o=0 and r+1.
  - A row with nnz 0 consumes one cycle with out_valid=0, then r advances.
  - After the last row completes, go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Arithmetic: o and o+g are in DW_CNT bits. Pointer col uses the low DW_COL bits, always < K after the clamp.

## Timing
- Reset (asynchronous assert, synchronous release) returns state to IDLE and sets these outputs to 0: busy, done, mem_ready, buf_write_data_en, buf_write_cidx_en, buf_idx, ptrs, lane_mask, out_valid.
- Reset mid-tile aborts the tile. No done pulse is emitted.
- Write strobes and buf_idx are registered: they assert in the cycle after the beat handshake.
- Load takes 2*M accepted beats; stalls on mem_valid=0 add cycles.
- ISSUE outputs are registered.
  - First group is valid one cycle after entering ISSUE.
  - ptrs/lane_mask hold stable while out_valid && !out_ready.
  - With out_ready=1, one group is issued per cycle.
- done is asserted one cycle after the final group is accepted. busy falls in the same cycle.

## Configuration
- STC_ABUF_PERF_EN defined: adds outputs perf_busy_cycles (32 bits, counts cycles with busy=1) and perf_stall_cycles (32 bits, counts out_valid && !out_ready).
  - Both counters clear on accepted start and on reset.
  - Both saturate at all-ones.
- Undefined: these ports and counters do not exist.

## Structure
- Shared package stc_pkg holds the FSM state enum, DW_PTR field offsets (row/col split) and the lane count constant 4.
- One sub-module: stc_abuf_grp_gen, combinational. Maps (r, o, nnz[r]) to ptrs, lane_mask and next-offset values.

## Test plan
- All rows nnz=16, out_ready=1: 32 load beats, then 64 groups, each with lane_mask=4'b1111. done is asserted 1 cycle after the last group is accepted.
- Row 0 nnz=5, other rows 0: row 0 issues {0,0..3} with mask 1111, then {0,4} with mask 0001. Then 15 empty-row bubbles, then done.
- nnz=20 on row 3: clamped to K. Row 3 issues exactly 4 full groups with cols 0..15.
- out_ready low for 3 cycles mid-ISSUE: ptrs held constant. With PERF_EN, perf_stall_cycles=3.
- mem_valid toggling during load: buf_idx sequence 0,0,1,1,…,15,15 with strobes alternating data then cidx.
- reset deasserted-to-asserted during ISSUE: all outputs are 0 immediately, with no done pulse. A following start runs a full tile correctly.

Source files
------------

// File: rtl/stc_pkg.sv
// Shared types and constants for the sparse tensor core A-buffer sequencer.
package stc_pkg;
  localparam int M           = 16;
  localparam int K           = 16;
  localparam int DW_MEM      = 512;
  localparam int DW_COL      = 4;
  localparam int DW_PTR      = 8;
  localparam int DW_CNT      = DW_COL + 1;
  localparam int LANES       = 4;
  localparam int PTR_ROW_LSB = DW_COL;
  localparam int PTR_COL_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_DATA, ST_LOAD_CIDX, ST_ISSUE, ST_DONE
  } abuf_state_e;

  typedef logic [DW_COL-1:0] row_t;
  typedef logic [DW_CNT-1:0] cnt_t;

  typedef struct packed {
    logic [LANES-1:0][DW_PTR-1:0] ptrs;
    logic [LANES-1:0]             mask;
    logic                         vld;
  } grp_t;

  function automatic cnt_t clamp_k(cnt_t c);
    return (c > cnt_t'(K)) ? cnt_t'(K) : c;
  endfunction
endpackage

// File: rtl/stc_abuf_ctrl_if.sv
// Memory-stream, buffer-write and pointer-issue signals of the A-buffer sequencer.
interface stc_abuf_ctrl_if;
  import stc_pkg::*;
  logic                    mem_valid;
  logic                    mem_ready;
  logic [DW_MEM-1:0]       mem_data;
  logic                    buf_write_data_en;
  logic                    buf_write_cidx_en;
  logic [DW_COL-1:0]       buf_idx;
  logic [DW_MEM-1:0]       buf_data_input;
  logic [LANES*DW_PTR-1:0] ptrs;
  logic [LANES-1:0]        lane_mask;
  logic                    out_valid;
  logic                    out_ready;

  // controller side
  modport slave (
    input  mem_valid, mem_data, out_ready,
    output mem_ready, buf_write_data_en, buf_write_cidx_en, buf_idx,
           buf_data_input, ptrs, lane_mask, out_valid
  );
  // memory fetch / consumer side
  modport master (
    output mem_valid, mem_data, out_ready,
    input  mem_ready, buf_write_data_en, buf_write_cidx_en, buf_idx,
           buf_data_input, ptrs, lane_mask, out_valid
  );
endinterface

// File: rtl/stc_abuf_grp_gen.sv
// Combinational pointer-group builder: (row, offset, row count) -> lane pointers,
// lane mask and the offset after this group.
module stc_abuf_grp_gen
  import stc_pkg::*;
(
  input  row_t row,
  input  cnt_t off,
  input  cnt_t nnz,
  output grp_t grp,
  output cnt_t off_next,
  output logic row_end
);
  cnt_t rem, len;
  logic [LANES-1:0][DW_PTR-1:0] ptrs_w;
  logic [LANES-1:0]             mask_w;

  assign rem      = (nnz > off) ? nnz - off : '0;
  assign len      = (rem > cnt_t'(LANES)) ? cnt_t'(LANES) : rem;
  assign off_next = off + len;
  assign row_end  = (off_next >= nnz);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    cnt_t col;
    assign col        = off + cnt_t'(g);
    assign mask_w[g]  = (cnt_t'(g) < len);
    // col < K after the clamp, so the low DW_COL bits are exact
    assign ptrs_w[g]  = mask_w[g] ? {row, col[DW_COL-1:0]} : '0;
  end

  assign grp = '{ptrs: ptrs_w, mask: mask_w, vld: (len != '0)};
endmodule

// File: rtl/stc_abuf_ctrl.sv
// A-operand row buffer sequencer: loads M value/column-index row pairs, then issues
// up to four {row,col} pointers per cycle. Optional STC_ABUF_PERF_EN adds perf counters.
module stc_abuf_ctrl
  import stc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [M*DW_CNT-1:0] nnz_vec,
  output logic                busy,
  output logic                done,
`ifdef STC_ABUF_PERF_EN
  output logic [31:0]         perf_busy_cycles,
  output logic [31:0]         perf_stall_cycles,
`endif
  stc_abuf_ctrl_if.slave      bus
);
  abuf_state_e     state_q, state_d;
  cnt_t [M-1:0]    nnz_q, nnz_d;
  row_t            r_q, r_d, buf_idx_q, buf_idx_d;
  cnt_t            o_q, o_d, o_nx;
  logic            last_q, last_d;
  logic            wr_data_q, wr_data_d, wr_cidx_q, wr_cidx_d;
  grp_t            grp_q, grp_d, grp_nx;
  logic            row_end, mem_ready_c;
  logic            beat, accept, adv, load_grp, finish;

  assign beat     = bus.mem_valid && mem_ready_c;
  assign accept   = grp_q.vld && bus.out_ready;
  // output register is free to take the next group
  assign adv      = (state_q == ST_ISSUE) && (!grp_q.vld || accept);
  assign load_grp = adv && !last_q;
  assign finish   = adv && last_q;

  stc_abuf_grp_gen u_grp (
    .row     (r_q),
    .off     (o_q),
    .nnz     (nnz_q[r_q]),
    .grp     (grp_nx),
    .off_next(o_nx),
    .row_end (row_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start) state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: if (beat)  state_d = ST_LOAD_CIDX;
      ST_LOAD_CIDX: if (beat)  state_d = (r_q == row_t'(M-1)) ? ST_ISSUE : ST_LOAD_DATA;
      ST_ISSUE:     if (finish) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ST_LOAD_DATA) || (state_q == ST_LOAD_CIDX) || (state_q == ST_ISSUE);
    mem_ready_c = (state_q == ST_LOAD_DATA) || (state_q == ST_LOAD_CIDX);
    done        = (state_q == ST_DONE);
  end

  always_comb begin
    nnz_d     = nnz_q;
    r_d       = r_q;
    o_d       = o_q;
    last_d    = last_q;
    buf_idx_d = buf_idx_q;
    grp_d     = grp_q;
    wr_data_d = beat && (state_q == ST_LOAD_DATA);
    wr_cidx_d = beat && (state_q == ST_LOAD_CIDX);
    if (beat) buf_idx_d = r_q;
    if ((state_q == ST_IDLE) && start) begin
      for (int i = 0; i < M; i++) nnz_d[i] = clamp_k(nnz_vec[i*DW_CNT +: DW_CNT]);
      r_d    = '0;
      o_d    = '0;
      last_d = 1'b0;
    end
    // row counter wraps to 0 after the last cidx row, ready for ISSUE
    if (wr_cidx_d) r_d = r_q + row_t'(1);
    if (load_grp) begin
      grp_d = grp_nx;
      if (row_end) begin
        o_d    = '0;
        r_d    = r_q + row_t'(1);
        last_d = (r_q == row_t'(M-1));
      end else begin
        o_d = o_nx;
      end
    end else if (finish) begin
      grp_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      nnz_q     <= '0;
      r_q       <= '0;
      o_q       <= '0;
      last_q    <= 1'b0;
      buf_idx_q <= '0;
      wr_data_q <= 1'b0;
      wr_cidx_q <= 1'b0;
      grp_q     <= '0;
    end else begin
      nnz_q     <= nnz_d;
      r_q       <= r_d;
      o_q       <= o_d;
      last_q    <= last_d;
      buf_idx_q <= buf_idx_d;
      wr_data_q <= wr_data_d;
      wr_cidx_q <= wr_cidx_d;
      grp_q     <= grp_d;
    end
  end

  assign bus.mem_ready         = mem_ready_c;
  assign bus.buf_write_data_en = wr_data_q;
  assign bus.buf_write_cidx_en = wr_cidx_q;
  assign bus.buf_idx           = buf_idx_q;
  assign bus.buf_data_input    = bus.mem_data;
  assign bus.ptrs              = grp_q.ptrs;
  assign bus.lane_mask         = grp_q.mask;
  assign bus.out_valid         = grp_q.vld;

`ifdef STC_ABUF_PERF_EN
  logic [31:0] pbusy_q, pbusy_d, pstall_q, pstall_d;

  always_comb begin
    pbusy_d  = pbusy_q;
    pstall_d = pstall_q;
    if ((state_q == ST_IDLE) && start) begin
      pbusy_d  = '0;
      pstall_d = '0;
    end else begin
      if (busy && !(&pbusy_q)) pbusy_d = pbusy_q + 32'd1;
      if (grp_q.vld && !bus.out_ready && !(&pstall_q)) pstall_d = pstall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pbusy_q  <= '0;
      pstall_q <= '0;
    end else begin
      pbusy_q  <= pbusy_d;
      pstall_q <= pstall_d;
    end
  end

  assign perf_busy_cycles  = pbusy_q;
  assign perf_stall_cycles = pstall_q;
`endif
endmodule

// File: tb/tb_stc_abuf_ctrl.sv
// Scoreboard bench for stc_abuf_ctrl: a reference model queues expected pointer groups
// at start; observed accepted groups and buffer-write strobes are compared per test.
module tb_stc_abuf_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [79:0] nnz_vec = '0;
  logic        busy, done;
`ifdef STC_ABUF_PERF_EN
  logic [31:0] pbusy, pstall;
`endif

  stc_abuf_ctrl_if bus();

  stc_abuf_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .nnz_vec(nnz_vec),
    .busy(busy), .done(done),
`ifdef STC_ABUF_PERF_EN
    .perf_busy_cycles(pbusy), .perf_stall_cycles(pstall),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [35:0] exp_g[$], obs_g[$];
  logic [31:0] hold_q[$];
  logic [5:0]  obs_w[$];
  int last_acc, done_cyc, done_cnt;
  logic busy_at_done;

  function automatic logic [79:0] all_rows(input int v);
    logic [79:0] x;
    for (int r = 0; r < 16; r++) x[r*5 +: 5] = 5'(v);
    return x;
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; bus.mem_valid = 1'b0; bus.out_ready = 1'b1;
    bus.mem_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    exp_g.delete();
  endtask

  // drives one start pulse and queues the groups the tile must produce
  task automatic start_tile(input logic [79:0] v);
    int c, L;
    logic [31:0] p;
    logic [3:0] mk;
    @(posedge clk); #1;
    nnz_vec = v; start = 1'b1;
    for (int r = 0; r < 16; r++) begin
      c = int'(v[r*5 +: 5]);
      if (c > 16) c = 16;
      for (int o = 0; o < c; o += 4) begin
        p = '0; mk = '0;
        L = (c - o < 4) ? c - o : 4;
        for (int g = 0; g < L; g++) begin
          p[g*8 +: 8] = 8'((r << 4) | (o + g));
          mk[g] = 1'b1;
        end
        exp_g.push_back({p, mk});
      end
    end
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic load_all(input bit toggle);
    int beats = 0, cyc = 0;
    obs_w.delete();
    while (beats < 32 && cyc < 300) begin
      bus.mem_valid = toggle ? (cyc % 3 != 1) : 1'b1;
      bus.mem_data  = {16{$urandom}};
      @(negedge clk);
      if (bus.buf_write_data_en || bus.buf_write_cidx_en)
        obs_w.push_back({bus.buf_write_data_en, bus.buf_write_cidx_en, bus.buf_idx});
      if (bus.mem_valid && bus.mem_ready) beats++;
      @(posedge clk); #1; cyc++;
    end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    if (bus.buf_write_data_en || bus.buf_write_cidx_en)
      obs_w.push_back({bus.buf_write_data_en, bus.buf_write_cidx_en, bus.buf_idx});
    @(posedge clk); #1;
  endtask

  // records accepted groups; drops out_ready for stall_len cycles after stall_at accepts
  task automatic issue_run(input int stall_at, input int stall_len);
    int cyc = 0, nacc = 0, scnt = 0;
    obs_g.delete(); hold_q.delete();
    last_acc = -1; done_cyc = -1; done_cnt = 0; busy_at_done = 1'b1;
    bus.out_ready = 1'b1;
    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        obs_g.push_back({bus.ptrs, bus.lane_mask}); last_acc = cyc; nacc++;
      end
      if (bus.out_valid && !bus.out_ready) hold_q.push_back(bus.ptrs);
      if (done) begin done_cyc = cyc; done_cnt++; busy_at_done = busy; end
      @(posedge clk); #1; cyc++;
      if (stall_len > 0 && nacc == stall_at && scnt < stall_len) begin
        bus.out_ready = 1'b0; scnt++;
      end else bus.out_ready = 1'b1;
    end
    @(negedge clk);
    if (done) done_cnt++;
  endtask

  task automatic test_reset();
    logic [511:0] d;
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({busy, done, bus.mem_ready, bus.out_valid} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctl got %b want 0000", {busy, done, bus.mem_ready, bus.out_valid});
    end
    n_tests++;
    if ({bus.buf_write_data_en, bus.buf_write_cidx_en, bus.buf_idx, bus.ptrs, bus.lane_mask} !== '0) begin
      n_fail++; $display("FAIL reset_data got %h want 0",
        {bus.buf_write_data_en, bus.buf_write_cidx_en, bus.buf_idx, bus.ptrs, bus.lane_mask});
    end
`ifdef STC_ABUF_PERF_EN
    n_tests++;
    if ({pbusy, pstall} !== 64'd0) begin
      n_fail++; $display("FAIL reset_perf got %h want 0", {pbusy, pstall});
    end
`endif
    d = {16{$urandom}};
    bus.mem_data = d;
    #1;
    n_tests++;
    if (bus.buf_data_input !== d) begin
      n_fail++; $display("FAIL data_fwd got %h want %h", bus.buf_data_input[31:0], d[31:0]);
    end
  endtask

  task automatic test_full();
    logic [35:0] got, want;
    start_tile(all_rows(16));
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy got %b want 1", busy); end
    load_all(1'b0);
    n_tests++;
    if (obs_w.size() !== 32) begin n_fail++; $display("FAIL full_writes got %0d want 32", obs_w.size()); end
    issue_run(0, 0);
    n_tests++;
    if (obs_g.size() !== 64) begin n_fail++; $display("FAIL full_ngrp got %0d want 64", obs_g.size()); end
    while (obs_g.size() > 0 && exp_g.size() > 0) begin
      got = obs_g.pop_front(); want = exp_g.pop_front();
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL full_grp got %h want %h", got, want); end
    end
    exp_g.delete();
    n_tests++;
    if (done_cyc !== last_acc + 1) begin
      n_fail++; $display("FAIL full_done_lat got %0d want %0d", done_cyc, last_acc + 1);
    end
    n_tests++;
    if (done_cnt !== 1 || busy_at_done !== 1'b0) begin
      n_fail++; $display("FAIL full_done_pulse got cnt=%0d busy=%b want cnt=1 busy=0", done_cnt, busy_at_done);
    end
`ifdef STC_ABUF_PERF_EN
    n_tests++;
    if (pbusy !== 32'd97) begin n_fail++; $display("FAIL full_perf_busy got %0d want 97", pbusy); end
`endif
  endtask

  task automatic test_sparse_row0();
    logic [79:0] v = '0;
    logic [35:0] got, want;
    v[4:0] = 5'd5;
    start_tile(v);
    nnz_vec = all_rows(16); start = 1'b1;   // ignored: controller already busy
    @(posedge clk); #1; start = 1'b0;
    load_all(1'b0);
    issue_run(0, 0);
    n_tests++;
    if (obs_g.size() !== 2) begin n_fail++; $display("FAIL sparse_ngrp got %0d want 2", obs_g.size()); end
    while (obs_g.size() > 0 && exp_g.size() > 0) begin
      got = obs_g.pop_front(); want = exp_g.pop_front();
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL sparse_grp got %h want %h", got, want); end
    end
    exp_g.delete();
    n_tests++;
    if (done_cyc - last_acc !== 16) begin
      n_fail++; $display("FAIL sparse_bubbles got %0d want 16", done_cyc - last_acc);
    end
  endtask

  task automatic test_clamp();
    logic [79:0] v = '0;
    logic [35:0] got, want;
    v[3*5 +: 5] = 5'd20;
    start_tile(v);
    load_all(1'b0);
    issue_run(0, 0);
    n_tests++;
    if (obs_g.size() !== 4) begin n_fail++; $display("FAIL clamp_ngrp got %0d want 4", obs_g.size()); end
    while (obs_g.size() > 0 && exp_g.size() > 0) begin
      got = obs_g.pop_front(); want = exp_g.pop_front();
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL clamp_grp got %h want %h", got, want); end
    end
    exp_g.delete();
  endtask

  task automatic test_stall();
    logic [35:0] got, want;
    logic [31:0] held;
    start_tile(all_rows(8));
    load_all(1'b0);
    held = exp_g[5][35:4];
    issue_run(5, 3);
    n_tests++;
    if (hold_q.size() !== 3) begin n_fail++; $display("FAIL stall_len got %0d want 3", hold_q.size()); end
    foreach (hold_q[i]) begin
      n_tests++;
      if (hold_q[i] !== held) begin n_fail++; $display("FAIL stall_hold got %h want %h", hold_q[i], held); end
    end
    n_tests++;
    if (obs_g.size() !== 32) begin n_fail++; $display("FAIL stall_ngrp got %0d want 32", obs_g.size()); end
    while (obs_g.size() > 0 && exp_g.size() > 0) begin
      got = obs_g.pop_front(); want = exp_g.pop_front();
      n_tests++;
      if (got !== want) begin n_fail++; $display("FAIL stall_grp got %h want %h", got, want); end
    end
    exp_g.delete();
`ifdef STC_ABUF_PERF_EN
    n_tests++;
    if (pstall !== 32'd3) begin n_fail++; $display("FAIL stall_perf got %0d want 3", pstall); end
`endif
  endtask

  task automatic test_mem_toggle();
    logic [5:0] want;
    logic [35:0] got, wg;
    start_tile(all_rows(1));
    load_all(1'b1);
    n_tests++;
    if (obs_w.size() !== 32) begin n_fail++; $display("FAIL tog_writes got %0d want 32", obs_w.size()); end
    for (int i = 0; i < 32 && i < obs_w.size(); i++) begin
      want = {(i % 2 == 0), (i % 2 == 1), 4'(i / 2)};
      n_tests++;
      if (obs_w[i] !== want) begin n_fail++; $display("FAIL tog_write[%0d] got %b want %b", i, obs_w[i], want); end
    end
    issue_run(0, 0);
    n_tests++;
    if (obs_g.size() !== 16) begin n_fail++; $display("FAIL tog_ngrp got %0d want 16", obs_g.size()); end
    while (obs_g.size() > 0 && exp_g.size() > 0) begin
      got = obs_g.pop_front(); wg = exp_g.pop_front();
      n_tests++;
      if (got !== wg) begin n_fail++; $display("FAIL tog_grp got %h want %h", got, wg); end
    end
    exp_g.delete();
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    start_tile(all_rows(16));
    load_all(1'b0);
    repeat (5) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, bus.mem_ready, bus.out_valid, bus.buf_write_data_en, bus.buf_write_cidx_en,
         bus.buf_idx, bus.ptrs, bus.lane_mask} !== '0) begin
      n_fail++; $display("FAIL midrst_outs got busy=%b vld=%b ptrs=%h want 0", busy, bus.out_valid, bus.ptrs);
    end
    repeat (2) begin @(negedge clk); if (done) dn++; end
    reset = 1'b1;
    exp_g.delete();
    repeat (3) begin @(negedge clk); if (done) dn++; end
    n_tests++;
    if (dn !== 0) begin n_fail++; $display("FAIL midrst_done got %0d want 0", dn); end
    test_full();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full();
    test_sparse_row0();
    test_clamp();
    test_stall();
    test_mem_toggle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
